// File: rtl/clk_view_pkg.sv
// Shared definitions for the viewer-clock generator: FSM encoding and parameter defaults.
package clk_view_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int              CNT_W_DEF        = 15;
  localparam logic [14:0]     DEFAULT_HALF_DEF = 15'd24999;
  localparam logic [14:0]     MIN_HALF_DEF     = 15'd1;

endpackage

// File: rtl/clk_half_cnt.sv
// Half-period counter: counts up while enabled and wraps to zero at the terminal value.
module clk_half_cnt #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt_reg;

  assign boundary = enable && (cnt_reg == terminal);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= boundary ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_view_ctrl.sv
// Viewer clock generator: programmable half-period with glitch-free reconfiguration and stop.
module clk_view_ctrl
  import clk_view_pkg::*;
#(
  parameter int               CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF),
  parameter logic [CNT_W-1:0] MIN_HALF     = CNT_W'(MIN_HALF_DEF)
) (
  input  logic             CLK_24,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk,
  output logic             tick,
  output logic             err,
  output logic             busy
);

  state_t           state_reg;
  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] pend_reg;
  logic             pend_valid_reg;
  logic             clk_reg;
  logic             tick_reg;
  logic             err_reg;

  logic accept;
  logic legal;
  logic boundary;
  logic active;
  logic stop_low;
  logic cnt_clear;

  assign cfg_ready = (state_reg == STOP) || (state_reg == RUN);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = accept && (cfg_half >= MIN_HALF);
  assign active    = (state_reg == RUN) || (state_reg == PEND);
  // Stopping during the low phase truncates it; the counter must restart from zero.
  assign stop_low  = active && !en && !clk_reg;
  assign cnt_clear = rst || stop_low;

  clk_half_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (CLK_24),
    .clear   (cnt_clear),
    .enable  (state_reg != STOP),
    .terminal(half_reg),
    .boundary(boundary)
  );

  always_ff @(posedge CLK_24) begin
    if (rst) begin
      state_reg      <= STOP;
      half_reg       <= DEFAULT_HALF;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      clk_reg        <= 1'b0;
      tick_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      err_reg  <= accept && !legal;
      case (state_reg)
        STOP: begin
          if (legal) half_reg <= cfg_half;
          if (en) state_reg <= RUN;
        end
        RUN, PEND: begin
          if (!en && (!clk_reg || boundary)) begin
            // Either a truncated low phase or the falling edge lands now: stop immediately.
            state_reg      <= STOP;
            clk_reg        <= 1'b0;
            tick_reg       <= clk_reg;
            pend_valid_reg <= 1'b0;
            if (legal) half_reg <= cfg_half;
            else if (pend_valid_reg) half_reg <= pend_reg;
          end else if (!en) begin
            state_reg <= DRAIN;
            if (legal) begin
              pend_reg       <= cfg_half;
              pend_valid_reg <= 1'b1;
            end
          end else begin
            if (boundary) begin
              clk_reg  <= ~clk_reg;
              tick_reg <= 1'b1;
            end
            if ((state_reg == PEND) && boundary) begin
              half_reg       <= pend_reg;
              pend_valid_reg <= 1'b0;
              state_reg      <= RUN;
            end else if (legal) begin
              pend_reg       <= cfg_half;
              pend_valid_reg <= 1'b1;
              state_reg      <= PEND;
            end
          end
        end
        DRAIN: begin
          if (boundary) begin
            clk_reg        <= 1'b0;
            tick_reg       <= 1'b1;
            state_reg      <= STOP;
            pend_valid_reg <= 1'b0;
            if (pend_valid_reg) half_reg <= pend_reg;
          end
        end
        default: state_reg <= STOP;
      endcase
    end
  end

  assign clk  = clk_reg;
  assign tick = tick_reg;
  assign err  = err_reg;
  assign busy = (state_reg != STOP);

endmodule

// File: tb/tb_clk_view_ctrl.sv
// Scoreboard bench: stimulus queues expected tick/err events, a monitor matches them as they appear.
module tb_clk_view_ctrl;

  localparam int CNT_W = 15;

  logic             CLK_24 = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready;
  logic             view_clk;
  logic             tick;
  logic             err;
  logic             busy;

  typedef struct {
    int   cyc;
    logic clk;
    logic err;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  clk_view_ctrl dut (
    .CLK_24   (CLK_24),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .clk      (view_clk),
    .tick     (tick),
    .err      (err),
    .busy     (busy)
  );

  always #5 CLK_24 = ~CLK_24;

  always @(posedge CLK_24) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLK_24);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic k, input logic e);
    ev_t ev;
    ev.cyc = c;
    ev.clk = k;
    ev.err = e;
    exp_q.push_back(ev);
  endtask

  // Monitor: every tick or err pulse must match the oldest expected event.
  always @(negedge CLK_24) begin
    ev_t ev;
    if (tick === 1'b1 || err === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: cyc %0d tick %b err %b clk %b, expected none", cyc, tick, err, view_clk);
      end else begin
        ev = exp_q.pop_front();
        $display("event cyc %0d tick %b err %b clk %b (expected cyc %0d clk %b err %b)",
                 cyc, tick, err, view_clk, ev.cyc, ev.clk, ev.err);
        chk("ev_cyc", cyc, ev.cyc);
        chk("ev_tick", int'(tick), 1);
        chk("ev_clk", int'(view_clk), int'(ev.clk));
        chk("ev_err", int'(err), int'(ev.err));
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    int c;
    @(posedge CLK_24);
    #1;
    // Reset behaviour
    wait_cyc(2);
    chk("rst_clk", int'(view_clk), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    chk("post_rst_ready", int'(cfg_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_clk", int'(view_clk), 0);
    chk("post_rst_err", int'(err), 0);

    // Default configuration: 25000-cycle phases
    en = 1'b1;
    push_ev(4 + 25001, 1'b1, 1'b0);
    push_ev(4 + 50001, 1'b0, 1'b0);
    wait_cyc(5);
    chk("run_busy", int'(busy), 1);
    wait_cyc(4 + 50001);
    en = 1'b0;
    wait_cyc(4 + 50002);
    chk("stop_low_busy", int'(busy), 0);

    // Load half=3 in STOP, then run
    a = cyc + 1;
    wait_cyc(a);
    chk("stop_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_half  = 15'd3;
    wait_cyc(a + 1);
    cfg_valid = 1'b0;
    en = 1'b1;
    push_ev(a + 6,  1'b1, 1'b0);
    push_ev(a + 10, 1'b0, 1'b0);
    push_ev(a + 14, 1'b1, 1'b0);
    push_ev(a + 18, 1'b0, 1'b0);
    wait_cyc(a + 3);
    chk("half3_busy", int'(busy), 1);

    // Reconfigure to half=1 at cnt=1 of a high phase
    wait_cyc(a + 15);
    chk("run_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_half  = 15'd1;
    wait_cyc(a + 16);
    cfg_valid = 1'b0;
    chk("pend_ready", int'(cfg_ready), 0);
    wait_cyc(a + 18);
    chk("pend_done_ready", int'(cfg_ready), 1);

    // Illegal config: err pulse coincides with the a+20 tick
    wait_cyc(a + 19);
    cfg_valid = 1'b1;
    cfg_half  = 15'd0;
    push_ev(a + 20, 1'b1, 1'b1);
    push_ev(a + 22, 1'b0, 1'b0);
    push_ev(a + 24, 1'b1, 1'b0);
    push_ev(a + 28, 1'b0, 1'b0);
    wait_cyc(a + 20);
    cfg_valid = 1'b0;
    wait_cyc(a + 21);
    chk("err_one_cycle", int'(err), 0);
    chk("err_state_ready", int'(cfg_ready), 1);

    // Back to half=3, then drop en in the high phase at cnt=1
    cfg_valid = 1'b1;
    cfg_half  = 15'd3;
    wait_cyc(a + 22);
    cfg_valid = 1'b0;
    wait_cyc(a + 23);
    chk("pend2_ready", int'(cfg_ready), 0);
    wait_cyc(a + 25);
    en = 1'b0;
    wait_cyc(a + 26);
    chk("drain_busy", int'(busy), 1);
    chk("drain_ready", int'(cfg_ready), 0);
    chk("drain_clk", int'(view_clk), 1);
    wait_cyc(a + 28);
    chk("drain_stop_busy", int'(busy), 0);
    chk("drain_stop_clk", int'(view_clk), 0);
    wait_cyc(a + 32);
    chk("stop_clk_stays", int'(view_clk), 0);

    // Drop en during the low phase: immediate stop
    b = a + 33;
    wait_cyc(b);
    en = 1'b1;
    push_ev(b + 5, 1'b1, 1'b0);
    push_ev(b + 9, 1'b0, 1'b0);
    wait_cyc(b + 10);
    en = 1'b0;
    wait_cyc(b + 11);
    chk("low_stop_busy", int'(busy), 0);
    chk("low_stop_clk", int'(view_clk), 0);

    // Restart (counter must be cleared), go to PEND, then reset
    c = b + 12;
    wait_cyc(c);
    en = 1'b1;
    push_ev(c + 5, 1'b1, 1'b0);
    wait_cyc(c + 6);
    cfg_valid = 1'b1;
    cfg_half  = 15'd1;
    wait_cyc(c + 7);
    cfg_valid = 1'b0;
    chk("pend3_ready", int'(cfg_ready), 0);
    rst = 1'b1;
    en  = 1'b0;
    wait_cyc(c + 8);
    rst = 1'b0;
    chk("mid_rst_clk", int'(view_clk), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cfg_ready), 1);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_err", int'(err), 0);

    // Default half restored and pending value discarded
    wait_cyc(c + 9);
    en = 1'b1;
    push_ev(c + 9 + 25001, 1'b1, 1'b0);
    wait_cyc(c + 9 + 25003);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_view_ctrl.md
CLK_VIEW_CTRL -- requirements
Module: clk_view_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 15: counter and config width.
REQ-002 SHALL have parameter DEFAULT_HALF, default 15'd24999: half-period terminal count after reset.
REQ-003 SHALL have parameter MIN_HALF, default 1: smallest legal half-period terminal count.
REQ-004 SHALL have port CLK_24  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  in  1  run request for the viewer clock.
REQ-007 SHALL have port cfg_valid  in  1  new half-period offered.
REQ-008 SHALL have port cfg_half  in  CNT_W  new terminal count (half-period minus 1, in CLK_24 cycles).
REQ-009 SHALL have port cfg_ready  out  1  config accepted when high with cfg_valid.
REQ-010 SHALL have port clk  out  1  generated viewer clock, registered.
REQ-011 SHALL have port tick  out  1  one-cycle pulse in the cycle clk toggles.
REQ-012 SHALL have port err  out  1  one-cycle pulse on a rejected config.
REQ-013 SHALL have port busy  out  1  high when state is not STOP.

Function
REQ-014 SHALL implement FSM states STOP, RUN, PEND and DRAIN.
REQ-015 SHALL keep cnt at 0 and clk at 0 in STOP.
REQ-016 In RUN, PEND and DRAIN, SHALL increment cnt each cycle; when cnt==half_r (the boundary), SHALL clear cnt, toggle clk and set tick=1 in the same edge.
REQ-017 SHALL drive cfg_ready combinationally high only in STOP and RUN; it is low in PEND and DRAIN.
REQ-018 On accept with cfg_half<MIN_HALF, SHALL pulse err for one cycle, leave state, half_r and pend_r unchanged, and not load the value.
REQ-019 On a legal accept in STOP, SHALL load half_r on the next edge.
REQ-020 On a legal accept in RUN, SHALL store pend_r and enter PEND; a boundary in the accept cycle uses the old half_r.
REQ-021 At the first boundary in PEND, SHALL load half_r<=pend_r and return to RUN; the new value governs the next phase.
REQ-022 STOP->RUN SHALL occur when en=1; the first toggle (clk 0->1) occurs half_r+1 cycles after entry.
REQ-023 In RUN or PEND with en=0 and clk=0, SHALL go directly to STOP with cnt cleared.
REQ-024 In RUN or PEND with en=0 and clk=1, SHALL enter DRAIN and continue counting; at the falling boundary it SHALL go to STOP with clk=0 and cnt=0.
REQ-025 SHALL load any pend_r still pending into half_r on entry to STOP from PEND or DRAIN.
REQ-026 SHALL ignore en=1 during DRAIN; restart only from STOP.
REQ-027 SHALL produce clk high and low phases of exactly half_r+1 cycles each; there are no runt phases except the truncated low phase in REQ-023.
REQ-028 SHALL saturate nothing; cnt never exceeds half_r, and a legal half_r<=2^CNT_W-1 needs no wrap handling.

Reset
REQ-029 While rst=1, SHALL set state=STOP, cnt=0, clk=0, tick=0, err=0, half_r=DEFAULT_HALF and pend_r=0.
REQ-030 rst SHALL override en and cfg_valid; a pending config is discarded, and reset mid-phase drops clk to 0 on the next edge.
REQ-031 SHALL make outputs valid from the first edge after rst deasserts; cfg_ready=1 and busy=0 at that point.

Structure
REQ-032 SHALL place the state encoding (STOP, RUN, PEND, DRAIN) and the CNT_W, DEFAULT_HALF and MIN_HALF defaults in shared package clk_view_pkg.
REQ-033 SHALL factor the load/increment/terminal-count counter into sub-module clk_half_cnt (inputs clear, enable, terminal value; output boundary); the FSM and handshake stay in clk_view_ctrl.

Verification
REQ-034 Reset, then en=1 with the default configuration -> first tick and clk rise 25000 cycles after entering RUN; period is 50000 cycles.
REQ-035 In STOP, accept cfg_half=3, then en=1 -> clk period 8 (4 high, 4 low); tick once every 4 cycles; busy=1.
REQ-036 RUN with half_r=3, accept cfg_half=1 at cnt=1 -> cfg_ready=0; the current phase ends after 2 more cycles; subsequent phases last 2 cycles; cfg_ready returns to 1.
REQ-037 Accept cfg_half=0 -> err=1 for exactly one cycle; phases remain unchanged; state remains unchanged.
REQ-038 With half_r=3, clk=1 and cnt=1, drop en -> DRAIN; clk falls 2 cycles later; STOP, busy=0, and clk stays 0. The same with clk=0 -> STOP on the next edge.
REQ-039 Assert rst for 1 cycle in PEND -> all outputs at reset values; half_r=24999; pend_r discarded.
